hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage datapath. Drives write-enable
//  (stall) and synchronous-clear (flush) of IF/ID, ID/EX, EX/MEM, MEM/WB registers.

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use, memory-wait (with timeout)
// and MEM-stage redirect hazards, and counts stalled fetch cycles.
module hazard_ctrl #(
    parameter int N       = 32,
    parameter int M       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] regA_D,
    input  logic [M-1:0] regB_D,
    input  logic         useB_D,
    input  logic [M-1:0] regScr_E,
    input  logic         regmem_E,
    input  logic         regw_E,
    input  logic         pcload_M,
    input  logic         memw_M,
    input  logic         regmem_M,
    input  logic         mem_ready,
    input  logic         err_clr,
    output logic         stall_F,
    output logic         stall_D,
    output logic         stall_E,
    output logic         stall_M,
    output logic         flush_D,
    output logic         flush_E,
    output logic         flush_M,
    output logic         flush_W,
    output logic         pc_sel,
    output logic         mem_err,
    output logic [N-1:0] stall_cnt
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

    state_t         state_q;
    logic [WW-1:0]  waitCnt_q;
    logic           memErr_q;
    logic [N-1:0]   stallCnt_q;
    logic [N-1:0]   stallCnt_d;

    logic memReq;
    logic luHit;
    logic holdAll;
    logic redirect;
    logic luStall;

    assign memReq = memw_M | regmem_M;
    assign luHit  = regmem_E & regw_E &
                    ((regScr_E == regA_D) | (useB_D & (regScr_E == regB_D)));

    // Priority is ERR > memory wait > redirect > load-use; everything is forced
    // low while reset is held so the pipeline sees no spurious controls.
    always_comb begin
        holdAll  = 1'b0;
        redirect = 1'b0;
        luStall  = 1'b0;
        if (rst) begin
            case (state_q)
                ERR:     holdAll = 1'b1;
                MEMWAIT: holdAll = ~mem_ready;
                default: holdAll = memReq & ~mem_ready;
            endcase
            redirect = ~holdAll & pcload_M;
            luStall  = ~holdAll & ~pcload_M & luHit;
        end
    end

    assign stall_F   = holdAll | luStall;
    assign stall_D   = holdAll | luStall;
    assign stall_E   = holdAll;
    assign stall_M   = holdAll;
    assign flush_D   = redirect;
    assign flush_E   = redirect | luStall;
    assign flush_M   = redirect;
    assign flush_W   = holdAll;
    assign pc_sel    = redirect;
    assign mem_err   = memErr_q;
    assign stall_cnt = stallCnt_q;

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall_F && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + N'(1);
        end
    end

    // waitCnt_q counts stalled memory cycles including the RUN entry cycle, so
    // reaching TIMEOUT-1 while still not ready means TIMEOUT cycles have elapsed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            waitCnt_q  <= '0;
            memErr_q   <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            case (state_q)
                RUN: begin
                    if (memReq && !mem_ready) begin
                        state_q   <= MEMWAIT;
                        waitCnt_q <= WW'(1);
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        state_q   <= RUN;
                        waitCnt_q <= '0;
                    end else if (waitCnt_q == WW'(TIMEOUT - 1)) begin
                        state_q   <= ERR;
                        waitCnt_q <= '0;
                        memErr_q  <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_q + WW'(1);
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        state_q  <= RUN;
                        memErr_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    waitCnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int N       = 4;
    localparam int M       = 4;
    localparam int TIMEOUT = 16;
    localparam int CNTMAX  = (1 << N) - 1;

    logic         clk;
    logic         rst;
    logic [M-1:0] regA_D;
    logic [M-1:0] regB_D;
    logic         useB_D;
    logic [M-1:0] regScr_E;
    logic         regmem_E;
    logic         regw_E;
    logic         pcload_M;
    logic         memw_M;
    logic         regmem_M;
    logic         mem_ready;
    logic         err_clr;
    logic         stall_F, stall_D, stall_E, stall_M;
    logic         flush_D, flush_E, flush_M, flush_W;
    logic         pc_sel;
    logic         mem_err;
    logic [N-1:0] stall_cnt;
    logic [8:0]   ctlVec;

    int checkCount = 0;
    int failCount  = 0;

    // Behavioural model: sticky error flag, stalled-memory-cycle count, total stalls
    bit mErr;
    int mWait;
    int mStalls;

    hazard_ctrl #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .regA_D(regA_D), .regB_D(regB_D), .useB_D(useB_D),
        .regScr_E(regScr_E), .regmem_E(regmem_E), .regw_E(regw_E),
        .pcload_M(pcload_M), .memw_M(memw_M), .regmem_M(regmem_M),
        .mem_ready(mem_ready), .err_clr(err_clr),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .pc_sel(pc_sel), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign ctlVec = {stall_F, stall_D, stall_E, stall_M,
                     flush_D, flush_E, flush_M, flush_W, pc_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setIdle();
        regA_D = '0; regB_D = '0; useB_D = 1'b0; regScr_E = '0;
        regmem_E = 1'b0; regw_E = 1'b0; pcload_M = 1'b0; memw_M = 1'b0;
        regmem_M = 1'b0; mem_ready = 1'b1; err_clr = 1'b0;
    endtask

    // Called at a falling edge with inputs already set; checks this cycle's
    // outputs, then advances the model past the coming rising edge.
    task automatic applyStimulus(input string tag);
        bit memReq, luHit, stuck, redirect, lUse, sF;
        int expCnt;
        #2;
        memReq   = memw_M | regmem_M;
        luHit    = regmem_E && regw_E &&
                   (regScr_E == regA_D || (useB_D && regScr_E == regB_D));
        stuck    = mErr || (!mem_ready && (mWait > 0 || memReq));
        redirect = !stuck && pcload_M;
        lUse     = !stuck && !pcload_M && luHit;
        sF       = stuck || lUse;
        expCnt   = (mStalls > CNTMAX) ? CNTMAX : mStalls;
        checkOutput({tag, "_ctl"}, 32'(ctlVec),
                    32'({sF, sF, stuck, stuck, redirect, redirect | lUse,
                         redirect, stuck, redirect}));
        checkOutput({tag, "_err"}, 32'(mem_err), 32'(mErr));
        checkOutput({tag, "_cnt"}, 32'(stall_cnt), 32'(expCnt));
        if (sF) mStalls++;
        if (mErr) begin
            if (err_clr) mErr = 1'b0;
        end else if (stuck) begin
            mWait++;
            if (mWait == TIMEOUT) begin
                mErr  = 1'b1;
                mWait = 0;
            end
        end else begin
            mWait = 0;
        end
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst = 1'b0;
        #1;
        checkOutput("rst_ctl", 32'(ctlVec), 32'd0);
        checkOutput("rst_err", 32'(mem_err), 32'd0);
        checkOutput("rst_cnt", 32'(stall_cnt), 32'd0);
        mErr = 1'b0; mWait = 0; mStalls = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        setIdle();
        applyReset();

        // Load-use on regA, then the load moves on
        regScr_E = 4'd3; regmem_E = 1'b1; regw_E = 1'b1; regA_D = 4'd3;
        applyStimulus("lu");
        setIdle();
        applyStimulus("lu_after");
        checkOutput("lu_cnt_one", 32'(stall_cnt), 32'd1);

        // regB match ignored when unused; non-load match ignored
        regScr_E = 4'd5; regB_D = 4'd5; regA_D = 4'd1; regmem_E = 1'b1; regw_E = 1'b1;
        applyStimulus("noB");
        regmem_E = 1'b0; regA_D = 4'd5;
        applyStimulus("noLoad");
        setIdle();

        // Load waits three cycles, released on the fourth
        applyReset();
        regmem_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("mwait");
        mem_ready = 1'b1;
        applyStimulus("mrel");
        setIdle();
        applyStimulus("mdone");
        checkOutput("mwait_cnt3", 32'(stall_cnt), 32'd3);

        // Redirect wins over load-use
        regScr_E = 4'd2; regmem_E = 1'b1; regw_E = 1'b1; regA_D = 4'd2; pcload_M = 1'b1;
        applyStimulus("pc_lu");
        setIdle();

        // Redirect held through a memory wait, acted on at release
        memw_M = 1'b1; pcload_M = 1'b1; mem_ready = 1'b0;
        applyStimulus("pcw0");
        applyStimulus("pcw1");
        mem_ready = 1'b1;
        applyStimulus("pcw_rel");
        setIdle();

        // Timeout into sticky error, mem_ready ignored, then clear
        applyReset();
        memw_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) applyStimulus("tmo");
        checkOutput("tmo_err", 32'(mem_err), 32'd1);
        mem_ready = 1'b1;
        applyStimulus("err_ign");
        err_clr = 1'b1;
        applyStimulus("err_clr");
        setIdle();
        applyStimulus("err_done");
        checkOutput("err_cleared", 32'(mem_err), 32'd0);

        // Asynchronous reset in the middle of a memory wait
        applyReset();
        memw_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus("prewait");
        #2;
        applyReset();
        setIdle();

        // Saturation of the stall counter
        memw_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus("sat");
        checkOutput("sat_cnt", 32'(stall_cnt), 32'(CNTMAX));
        setIdle();
        applyReset();

        // Randomized traffic with small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            regA_D    = M'($urandom_range(0, 3));
            regB_D    = M'($urandom_range(0, 3));
            regScr_E  = M'($urandom_range(0, 3));
            useB_D    = 1'($urandom_range(0, 1));
            regmem_E  = ($urandom_range(0, 2) == 0);
            regw_E    = ($urandom_range(0, 3) != 0);
            pcload_M  = ($urandom_range(0, 5) == 0);
            memw_M    = ($urandom_range(0, 6) == 0);
            regmem_M  = ($urandom_range(0, 6) == 0);
            mem_ready = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
            err_clr   = ($urandom_range(0, 7) == 0);
            applyStimulus("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
